// File: rtl/invader_march_ctrl.sv
// Alien formation march sequencer: frame-paced steps, edge drops, landing and clear detection.
// Optional build macro MARCH_SPEEDUP_EN: step period shrinks with the number of live invaders.
module invader_march_ctrl #(
    parameter int COLS        = 8,
    parameter int ROWS        = 4,
    parameter int CELL_W      = 16,
    parameter int CELL_H      = 16,
    parameter int X_START     = 64,
    parameter int Y_START     = 48,
    parameter int X_MIN       = 8,
    parameter int X_MAX       = 632,
    parameter int Y_LIMIT     = 416,
    parameter int STEP_X      = 4,
    parameter int STEP_Y      = 8,
    parameter int BASE_PERIOD = 32,
    parameter int MIN_PERIOD  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_tick,
    input  logic                 game_run,
    input  logic                 level_start,
    input  logic [COLS*ROWS-1:0] alive_mask,
    output logic [9:0]           form_x,
    output logic [9:0]           form_y,
    output logic                 dir,
    output logic                 anim,
    output logic                 step_pulse,
    output logic                 landed,
    output logic                 cleared
);

    localparam int NCELLS     = COLS * ROWS;
    localparam int MAX_PERIOD = (MIN_PERIOD + NCELLS > BASE_PERIOD) ? MIN_PERIOD + NCELLS : BASE_PERIOD;
    localparam int CNT_W      = $clog2(MAX_PERIOD + 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        MOVE,
        LANDED,
        CLEARED
    } state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  frame_cnt, cnt_n, cnt_inc, period;
    logic [9:0]        x_n, y_n;
    logic              dir_n, anim_n, step_n, landed_n, cleared_n;
    logic              tick_q;

    logic [COLS-1:0]   col_any;
    logic [ROWS-1:0]   row_any;
    logic [10:0]       lc, rc, br;
    logic [10:0]       right_sum, left_sum, drop_y, land_sum;
    logic              hit_edge;

    // Column/row occupancy reduced to leftmost, rightmost and bottom live extents.
    always_comb begin
        col_any = '0;
        row_any = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (alive_mask[r*COLS + c]) begin
                    col_any[c] = 1'b1;
                    row_any[r] = 1'b1;
                end
            end
        end
        lc = '0;
        for (int c = COLS - 1; c >= 0; c--) begin
            if (col_any[c]) lc = 11'(c);
        end
        rc = '0;
        for (int c = 0; c < COLS; c++) begin
            if (col_any[c]) rc = 11'(c);
        end
        br = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (row_any[r]) br = 11'(r);
        end
    end

`ifdef MARCH_SPEEDUP_EN
    logic [CNT_W-1:0] live_cnt;

    always_comb begin
        live_cnt = '0;
        for (int i = 0; i < NCELLS; i++) begin
            live_cnt = live_cnt + CNT_W'(alive_mask[i]);
        end
        period = CNT_W'(MIN_PERIOD) + live_cnt;
    end
`else
    assign period = CNT_W'(BASE_PERIOD);
`endif

    // Edge sums are one bit wider than the origin so they never wrap.
    always_comb begin
        right_sum = {1'b0, form_x} + (rc + 11'd1) * 11'(CELL_W) + 11'(STEP_X);
        left_sum  = {1'b0, form_x} + lc * 11'(CELL_W);
        drop_y    = {1'b0, form_y} + 11'(STEP_Y);
        land_sum  = drop_y + (br + 11'd1) * 11'(CELL_H);
        hit_edge  = dir ? (right_sum > 11'(X_MAX)) : (left_sum < 11'(X_MIN + STEP_X));
        cnt_inc   = frame_cnt + CNT_W'(1);
    end

    always_comb begin
        state_n   = state;
        cnt_n     = frame_cnt;
        x_n       = form_x;
        y_n       = form_y;
        dir_n     = dir;
        anim_n    = anim;
        step_n    = 1'b0;
        landed_n  = landed;
        cleared_n = cleared;
        if (level_start) begin
            state_n   = WAIT;
            cnt_n     = '0;
            x_n       = 10'(X_START);
            y_n       = 10'(Y_START);
            dir_n     = 1'b1;
            anim_n    = 1'b0;
            landed_n  = 1'b0;
            cleared_n = 1'b0;
        end else begin
            case (state)
                WAIT: begin
                    // Comparing with >= lets a shrinking period fire on the very next tick.
                    if (tick_q) begin
                        if (cnt_inc >= period) begin
                            cnt_n   = '0;
                            state_n = MOVE;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end
                end
                MOVE: begin
                    if (alive_mask == '0) begin
                        state_n   = CLEARED;
                        cleared_n = 1'b1;
                    end else begin
                        state_n = WAIT;
                        anim_n  = ~anim;
                        step_n  = 1'b1;
                        if (hit_edge) begin
                            y_n   = drop_y[9:0];
                            dir_n = ~dir;
                            if (land_sum >= 11'(Y_LIMIT)) begin
                                state_n  = LANDED;
                                landed_n = 1'b1;
                            end
                        end else if (dir) begin
                            x_n = form_x + 10'(STEP_X);
                        end else begin
                            x_n = form_x - 10'(STEP_X);
                        end
                    end
                end
                IDLE, LANDED, CLEARED: begin
                    state_n = state;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // The tick is registered once, which places the MOVE cycle one clock after the counting edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            frame_cnt  <= '0;
            tick_q     <= 1'b0;
            form_x     <= 10'(X_START);
            form_y     <= 10'(Y_START);
            dir        <= 1'b1;
            anim       <= 1'b0;
            step_pulse <= 1'b0;
            landed     <= 1'b0;
            cleared    <= 1'b0;
        end else begin
            state      <= state_n;
            frame_cnt  <= cnt_n;
            tick_q     <= frame_tick & game_run & ~level_start;
            form_x     <= x_n;
            form_y     <= y_n;
            dir        <= dir_n;
            anim       <= anim_n;
            step_pulse <= step_n;
            landed     <= landed_n;
            cleared    <= cleared_n;
        end
    end

endmodule
